// File: rtl/alu_seq_exec_pkg.sv
// Shared op codes, FSM encoding and decode helpers for the sequential execute ALU.
package alu_pkg;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_XOR = 5'b01101;
    localparam logic [4:0] ALU_SRL = 5'b10000;
    localparam logic [4:0] ALU_SRA = 5'b11000;
    localparam logic [4:0] ALU_SLL = 5'b11001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift(input logic [4:0] conf);
        return (conf == ALU_SRL) || (conf == ALU_SRA) || (conf == ALU_SLL);
    endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Request/response handshake bundle between the controller and the execute ALU.
interface alu_seq_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       ALUConf;
    logic             Sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Overflow;

    // Controller side: offers ops, consumes results.
    modport master (
        output in_valid, ALUConf, Sign, A, B, out_ready,
        input  in_ready, out_valid, Result, Zero, Overflow
    );

    // ALU side.
    modport slave (
        input  in_valid, ALUConf, Sign, A, B, out_ready,
        output in_ready, out_valid, Result, Zero, Overflow
    );
endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: logic/arith ops, set-less-than and signed overflow.
// Shift codes pass B through, which is the correct result for a zero shift amount.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       conf_i,
    input  logic             sign_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o
);
    localparam int M = WIDTH - 1;

    logic [WIDTH-1:0] sum, diff;
    logic             lt;

    assign sum  = a_i + b_i;
    assign diff = a_i + ~b_i + {{(WIDTH-1){1'b0}}, 1'b1};
    assign lt   = sign_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);

    // Op select; overflow only for signed ADD/SUB.
    always_comb begin
        res_o = sum;
        ovf_o = 1'b0;
        case (conf_i)
            ALU_ADD: begin
                res_o = sum;
                ovf_o = sign_i && (a_i[M] == b_i[M]) && (sum[M] != a_i[M]);
            end
            ALU_SUB: begin
                res_o = diff;
                ovf_o = sign_i && (a_i[M] != b_i[M]) && (diff[M] != a_i[M]);
            end
            ALU_OR:  res_o = a_i | b_i;
            ALU_AND: res_o = a_i & b_i;
            ALU_NOR: res_o = ~(a_i | b_i);
            ALU_XOR: res_o = a_i ^ b_i;
            ALU_SLT: res_o = {{(WIDTH-1){1'b0}}, lt};
            ALU_SRL, ALU_SRA, ALU_SLL: res_o = b_i;
            default: res_o = sum;
        endcase
    end
endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: one-cycle logic/arith, bit-serial shifts, valid/ready on both sides.
// The result register doubles as the shift register while a shift is in flight.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic          clk,
    input logic          reset,
    alu_seq_exec_if.slave bus
);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             arith_q, arith_d;

    logic [WIDTH-1:0] core_res;
    logic             core_ovf;
    logic [WIDTH-1:0] shifted;
    logic [SHW-1:0]   shamt;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .conf_i (bus.ALUConf),
        .sign_i (bus.Sign),
        .a_i    (bus.A),
        .b_i    (bus.B),
        .res_o  (core_res),
        .ovf_o  (core_ovf)
    );

    assign shamt = bus.A[SHW-1:0];

    // One-bit step of the in-flight shift.
    always_comb begin
        if (left_q)
            shifted = {res_q[WIDTH-2:0], 1'b0};
        else
            shifted = {arith_q & res_q[WIDTH-1], res_q[WIDTH-1:1]};
    end

    // FSM and datapath next state.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift(bus.ALUConf) && (shamt != '0)) begin
                        res_d   = bus.B;
                        ovf_d   = 1'b0;
                        cnt_d   = shamt;
                        left_d  = bus.ALUConf[0];
                        arith_d = bus.ALUConf[3];
                        state_d = ST_SHIFT;
                    end else begin
                        res_d   = core_res;
                        ovf_d   = core_ovf;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                res_d = shifted;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d = (res_d == '0);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.Result    = res_q;
    assign bus.Zero      = zero_q;
    assign bus.Overflow  = ovf_q;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: reset, arith/logic ops, shift latency, backpressure, mid-shift reset.
module tb_alu_seq_exec;
    import alu_pkg::*;

    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    alu_seq_exec_if #(.WIDTH(32)) bus ();

    alu_seq_exec #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one op, then wait (bounded) for out_valid; lat counts edges from accept.
    task automatic do_op(input logic [4:0] conf, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output logic rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        bus.in_valid = 1'b1;
        bus.ALUConf  = conf;
        bus.Sign     = sgn;
        bus.A        = a;
        bus.B        = b;
        @(posedge clk); #1;
        // Scramble inputs after accept; the unit must ignore them.
        bus.in_valid = 1'b0;
        bus.ALUConf  = ALU_SUB;
        bus.Sign     = ~sgn;
        bus.A        = 32'h5555_5555;
        bus.B        = 32'hAAAA_AAAA;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) begin
            n_chk++; n_fail++;
            $display("FAIL timeout: out_valid=%b after %0d cycles, want 1", bus.out_valid, lat);
        end
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({bus.in_ready, bus.out_valid, bus.Result, bus.Zero, bus.Overflow} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b res=%h z=%b o=%b want 1 0 00000000 1 0",
                     bus.in_ready, bus.out_valid, bus.Result, bus.Zero, bus.Overflow);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_ovf();
        int lat; logic rs;
        do_op(ALU_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, lat, rs);
        n_chk++;
        if ({lat, bus.Result, bus.Zero, bus.Overflow} !== {32'd1, 32'h8000_0000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_signed: lat=%0d res=%h z=%b o=%b want 1 80000000 0 1", lat, bus.Result, bus.Zero, bus.Overflow);
        end
        take_result();
        do_op(ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, lat, rs);
        n_chk++;
        if ({lat, bus.Result, bus.Zero, bus.Overflow} !== {32'd1, 32'h8000_0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add_unsigned: lat=%0d res=%h z=%b o=%b want 1 80000000 0 0", lat, bus.Result, bus.Zero, bus.Overflow);
        end
        take_result();
        do_op(ALU_SUB, 1'b1, 32'h8000_0000, 32'h1, lat, rs);
        n_chk++;
        if ({bus.Result, bus.Overflow} !== {32'h7FFF_FFFF, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_ovf: res=%h o=%b want 7fffffff 1", bus.Result, bus.Overflow);
        end
        take_result();
    endtask

    task automatic test_slt();
        int lat; logic rs;
        do_op(ALU_SLT, 1'b1, 32'hFFFF_FFFF, 32'h1, lat, rs);
        n_chk++;
        if ({bus.Result, bus.Zero, bus.Overflow} !== {32'h1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL slt_signed: res=%h z=%b o=%b want 00000001 0 0", bus.Result, bus.Zero, bus.Overflow);
        end
        take_result();
        do_op(ALU_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1, lat, rs);
        n_chk++;
        if ({bus.Result, bus.Zero} !== {32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL slt_unsigned: res=%h z=%b want 00000000 1", bus.Result, bus.Zero);
        end
        take_result();
    endtask

    task automatic test_logic();
        logic [4:0]  ops [5] = '{ALU_OR, ALU_AND, ALU_XOR, ALU_NOR, 5'b11111};
        logic [31:0] exp [5] = '{32'hFFF0_FF34, 32'h00F0_1200, 32'hFF00_ED34, 32'h000F_00CB, 32'h00E1_1134};
        int lat; logic rs;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, lat, rs);
            n_chk++;
            if ({lat, bus.Result, bus.Overflow} !== {32'd1, exp[i], 1'b0}) begin
                n_fail++;
                $display("FAIL logic_op%0d: lat=%0d res=%h o=%b want 1 %h 0", i, lat, bus.Result, bus.Overflow, exp[i]);
            end
            take_result();
        end
    endtask

    task automatic test_shift();
        int lat; logic rs;
        do_op(ALU_SRA, 1'b0, 32'd31, 32'h8000_0000, lat, rs);
        n_chk++;
        if ({lat, bus.Result, bus.Zero} !== {32'd32, 32'hFFFF_FFFF, 1'b0}) begin
            n_fail++;
            $display("FAIL sra31: lat=%0d res=%h z=%b want 32 ffffffff 0", lat, bus.Result, bus.Zero);
        end
        take_result();
        do_op(ALU_SRL, 1'b0, 32'd31, 32'h8000_0000, lat, rs);
        n_chk++;
        if ({lat, bus.Result} !== {32'd32, 32'h1}) begin
            n_fail++;
            $display("FAIL srl31: lat=%0d res=%h want 32 00000001", lat, bus.Result);
        end
        take_result();
        do_op(ALU_SLL, 1'b0, 32'd0, 32'hDEAD_BEEF, lat, rs);
        n_chk++;
        if ({lat, bus.Result} !== {32'd1, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL sll0: lat=%0d res=%h want 1 deadbeef", lat, bus.Result);
        end
        take_result();
        // Upper bits of A are not part of the shift amount.
        do_op(ALU_SLL, 1'b0, 32'hFFFF_FFE4, 32'hDEAD_BEEF, lat, rs);
        n_chk++;
        if ({lat, bus.Result, rs} !== {32'd5, 32'hEADB_EEF0, 1'b0}) begin
            n_fail++;
            $display("FAIL sll4: lat=%0d res=%h rdy_in_shift=%b want 5 eadbeef0 0", lat, bus.Result, rs);
        end
        take_result();
        do_op(ALU_SRA, 1'b0, 32'd4, 32'h7000_0010, lat, rs);
        n_chk++;
        if ({lat, bus.Result, bus.Zero, rs} !== {32'd5, 32'h0700_0001, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sra4_pos: lat=%0d res=%h z=%b rdy_in_shift=%b want 5 07000001 0 0", lat, bus.Result, bus.Zero, rs);
        end
        take_result();
        do_op(ALU_SRL, 1'b0, 32'd8, 32'h0000_00FF, lat, rs);
        n_chk++;
        if ({bus.Result, bus.Zero} !== {32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL srl_to_zero: res=%h z=%b want 00000000 1", bus.Result, bus.Zero);
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        int lat; logic rs;
        do_op(ALU_SUB, 1'b1, 32'd5, 32'd5, lat, rs);
        for (int c = 0; c < 5; c++) begin
            n_chk++;
            if ({bus.out_valid, bus.in_ready, bus.Result, bus.Zero, bus.Overflow} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_c%0d: vld=%b rdy=%b res=%h z=%b o=%b want 1 0 00000000 1 0",
                         c, bus.out_valid, bus.in_ready, bus.Result, bus.Zero, bus.Overflow);
            end
            @(posedge clk); #1;
        end
        take_result();
        n_chk++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL release_idle: rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        do_op(ALU_ADD, 1'b0, 32'd3, 32'd4, lat, rs);
        n_chk++;
        if ({lat, bus.Result} !== {32'd1, 32'd7}) begin
            n_fail++;
            $display("FAIL next_accept: lat=%0d res=%h want 1 00000007", lat, bus.Result);
        end
        take_result();
    endtask

    task automatic test_reset_midshift();
        int vld_seen = 0;
        bus.in_valid = 1'b1;
        bus.ALUConf  = ALU_SLL;
        bus.Sign     = 1'b0;
        bus.A        = 32'd10;
        bus.B        = 32'h1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        n_chk++;
        if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL midshift_busy: rdy=%b vld=%b want 0 0", bus.in_ready, bus.out_valid);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if ({bus.in_ready, bus.out_valid, bus.Result, bus.Zero} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL midshift_reset: rdy=%b vld=%b res=%h z=%b want 1 0 00000000 1",
                     bus.in_ready, bus.out_valid, bus.Result, bus.Zero);
        end
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) vld_seen++;
        end
        bus.out_ready = 1'b0;
        n_chk++;
        if (vld_seen !== 0) begin
            n_fail++;
            $display("FAIL stale_result: out_valid seen %0d cycles want 0", vld_seen);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.ALUConf   = ALU_ADD;
        bus.Sign      = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;
        test_reset();
        test_add_ovf();
        test_slt();
        test_logic();
        test_shift();
        test_back_to_back();
        test_reset_midshift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
